// File: rtl/hc161_pkg.sv
// ============================================================================
// hc161_pkg : shared types and helpers for the HC161 cascade timer controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hc161_pkg;

   localparam int c_slice_w = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Two's-complement of the period at the given width; a period of 0 yields 0 (full 2^W span).
   function automatic logic [63:0] load_value(input logic [63:0] period, input int width);
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (64'd0 - period) & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hc161_period_cnt.sv
// ============================================================================
// hc161_period_cnt : registered done pulse and completed-period counter
// Rev 1.0
// ============================================================================
`default_nettype none

module hc161_period_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_term,
   output logic             o_done,
   output logic [CNT_W-1:0] o_periods
);

   logic             r_done;
   logic [CNT_W-1:0] r_periods;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done    <= 1'b0;
         r_periods <= '0;
      end else begin
         r_done <= i_term;
         if (i_clear)
            r_periods <= '0;
         else if (i_term)
            r_periods <= r_periods + 1'b1;
      end
   end

   assign o_done    = r_done;
   assign o_periods = r_periods;

endmodule

`default_nettype wire

// File: rtl/hc161_timer_ctrl.sv
// ============================================================================
// hc161_timer_ctrl : start/stop sequencer driving a cascade of HC161 counters
// Rev 1.0
// ============================================================================
`default_nettype none

module hc161_timer_ctrl
   import hc161_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int CNT_W  = 8
) (
   input  logic                          CP,
   input  logic                          MR,
   input  logic                          start_i,
   input  logic                          stop_i,
   input  logic                          reload_i,
   input  logic [c_slice_w*STAGES-1:0]   period_i,
   input  logic                          tick_i,
   input  logic                          cnt_tc_i,
   output logic                          cnt_mr_n_o,
   output logic                          cnt_pe_n_o,
   output logic                          cnt_cep_o,
   output logic                          cnt_cet_o,
   output logic [c_slice_w*STAGES-1:0]   cnt_d_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [CNT_W-1:0]              periods_o
);

   localparam int W = c_slice_w * STAGES;

   state_t         r_state;
   logic [W-1:0]   r_period;
   logic           r_reload;
   logic [W-1:0]   w_load;
   logic           w_start;
   logic           w_tc_evt;
   logic           w_term;

   assign w_load   = W'(load_value(64'(r_period), W));
   assign w_start  = (r_state == IDLE) && start_i && !stop_i;
   // A stalled TC (tick low) must not end the period.
   assign w_tc_evt = (r_state == RUN) && cnt_tc_i && tick_i;
   assign w_term   = w_tc_evt && !stop_i;

   always_ff @(posedge CP) begin
      if (MR) begin
         r_state  <= IDLE;
         r_period <= '0;
         r_reload <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_period <= period_i;
                  r_reload <= reload_i;
                  r_state  <= LOAD;
               end
            end
            LOAD:    r_state <= stop_i ? IDLE : RUN;
            RUN: begin
               if (stop_i || (w_tc_evt && !r_reload))
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_mr_n_o = 1'b0;
      cnt_pe_n_o = 1'b1;
      cnt_cep_o  = 1'b0;
      cnt_cet_o  = 1'b0;
      cnt_d_o    = '0;
      case (r_state)
         LOAD: begin
            cnt_mr_n_o = 1'b1;
            cnt_pe_n_o = 1'b0;
            cnt_d_o    = w_load;
         end
         RUN: begin
            cnt_mr_n_o = 1'b1;
            cnt_cet_o  = 1'b1;
            cnt_cep_o  = tick_i;
            cnt_d_o    = w_load;
            cnt_pe_n_o = !(w_term && r_reload);
         end
         default: ;
      endcase
   end

   assign busy_o = (r_state != IDLE);

   hc161_period_cnt #(
      .CNT_W (CNT_W)
   ) u_period_cnt (
      .clk       (CP),
      .rst       (MR),
      .i_clear   (w_start),
      .i_term    (w_term),
      .o_done    (done_o),
      .o_periods (periods_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_hc161_timer_ctrl.sv
// ============================================================================
// tb_hc161_timer_ctrl : HC161 cascade load plus tick-counting reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hc161_timer_ctrl;

   localparam int STAGES = 2;
   localparam int CNT_W  = 8;
   localparam int W      = 4 * STAGES;
   localparam int SPAN   = 1 << W;

   logic             CP = 1'b0;
   logic             MR, start_i, stop_i, reload_i, tick_i, cnt_tc_i;
   logic [W-1:0]     period_i;
   logic             cnt_mr_n_o, cnt_pe_n_o, cnt_cep_o, cnt_cet_o;
   logic [W-1:0]     cnt_d_o;
   logic             busy_o, done_o;
   logic [CNT_W-1:0] periods_o;

   int n_vec = 0;
   int n_err = 0;

   hc161_timer_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .CP(CP), .MR(MR), .start_i(start_i), .stop_i(stop_i), .reload_i(reload_i),
      .period_i(period_i), .tick_i(tick_i), .cnt_tc_i(cnt_tc_i),
      .cnt_mr_n_o(cnt_mr_n_o), .cnt_pe_n_o(cnt_pe_n_o), .cnt_cep_o(cnt_cep_o),
      .cnt_cet_o(cnt_cet_o), .cnt_d_o(cnt_d_o), .busy_o(busy_o), .done_o(done_o),
      .periods_o(periods_o)
   );

   always #5 CP = ~CP;

   // HC161 slices, ripple-carry: TC of each stage feeds CET of the next
   logic [3:0]        q [STAGES];
   logic [STAGES-1:0] cet_s;
   logic [W-1:0]      cnt_val;

   always_comb begin
      logic en;
      en      = cnt_cet_o;
      cnt_val = '0;
      cet_s   = '0;
      for (int k = 0; k < STAGES; k++) begin
         cet_s[k]          = en;
         en                = en && (q[k] == 4'hF);
         cnt_val[4*k +: 4] = q[k];
      end
      cnt_tc_i = en;
   end

   always @(posedge CP) begin
      for (int k = 0; k < STAGES; k++) begin
         if (!cnt_mr_n_o)
            q[k] <= 4'h0;
         else if (!cnt_pe_n_o)
            q[k] <= cnt_d_o[4*k +: 4];
         else if (cnt_cep_o && cet_s[k])
            q[k] <= q[k] + 4'd1;
      end
   end

   // Reference model: ticks remaining in the current period
   bit m_valid = 1'b0;
   bit m_active, m_loading, m_auto, m_done;
   int m_P, m_rem, m_periods;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit mr, input bit st, input bit sp, input bit rl,
                       input logic [W-1:0] per, input bit tk);
      bit nd;
      int lval;
      @(negedge CP);
      MR = mr; start_i = st; stop_i = sp; reload_i = rl; period_i = per; tick_i = tk;
      #1;
      if (m_valid) begin
         lval = (SPAN - m_P) % SPAN;
         chk("busy", 64'(busy_o), 64'(m_active));
         chk("done", 64'(done_o), 64'(m_done));
         chk("periods", 64'(periods_o), 64'(m_periods));
         chk("mr_n", 64'(cnt_mr_n_o), 64'(m_active));
         if (!m_active) begin
            chk("idle_pe_n", 64'(cnt_pe_n_o), 64'd1);
            chk("idle_cep", 64'(cnt_cep_o), 64'd0);
            chk("idle_cet", 64'(cnt_cet_o), 64'd0);
            chk("idle_d", 64'(cnt_d_o), 64'd0);
         end else if (m_loading) begin
            chk("load_pe_n", 64'(cnt_pe_n_o), 64'd0);
            chk("load_cep", 64'(cnt_cep_o), 64'd0);
            chk("load_cet", 64'(cnt_cet_o), 64'd0);
            chk("load_d", 64'(cnt_d_o), 64'(lval));
         end else begin
            chk("run_count", 64'(cnt_val), 64'((SPAN - m_rem) % SPAN));
            chk("run_cep", 64'(cnt_cep_o), 64'(tk));
            chk("run_cet", 64'(cnt_cet_o), 64'd1);
            chk("run_d", 64'(cnt_d_o), 64'(lval));
            if (!sp)
               chk("run_pe_n", 64'(cnt_pe_n_o), 64'(!(tk && m_rem == 1 && m_auto)));
         end
      end
      nd = 1'b0;
      if (mr) begin
         m_valid = 1'b1; m_active = 1'b0; m_loading = 1'b0; m_periods = 0;
      end else if (m_valid) begin
         if (!m_active) begin
            if (st && !sp) begin
               m_active = 1'b1; m_loading = 1'b1; m_auto = rl; m_periods = 0;
               m_P = (per == '0) ? SPAN : int'(per);
            end
         end else if (m_loading) begin
            m_loading = 1'b0;
            if (sp) m_active = 1'b0;
            else    m_rem = m_P;
         end else if (sp) begin
            m_active = 1'b0;
         end else if (tk) begin
            if (m_rem == 1) begin
               nd = 1'b1;
               m_periods = (m_periods + 1) % (1 << CNT_W);
               if (m_auto) m_rem = m_P;
               else        m_active = 1'b0;
            end else begin
               m_rem--;
            end
         end
      end
      m_done = nd;
      @(posedge CP);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
   endtask

   initial begin
      int saved;
      MR = 1'b1; start_i = 0; stop_i = 0; reload_i = 0; period_i = '0; tick_i = 0;
      // reset then quiet idle
      step(1, 0, 0, 0, '0, 0);
      step(1, 0, 0, 0, '0, 0);
      idle(5);
      chk("reset_periods", 64'(periods_o), 64'd0);

      // one-shot, period 10
      step(0, 1, 0, 0, 8'd10, 1);
      chk("oneshot_load_d", 64'(cnt_d_o), 64'hF6);
      for (int i = 0; i < 40 && m_active; i++) step(0, 0, 0, 0, 8'd10, 1);
      idle(2);
      chk("oneshot_periods", 64'(periods_o), 64'd1);
      chk("oneshot_busy", 64'(busy_o), 64'd0);

      // auto-reload, period 3, tick every other cycle
      step(0, 1, 0, 1, 8'd3, 0);
      for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 8'd3, bit'(i % 2));
      chk("auto_periods", 64'(periods_o), 64'd4);
      step(0, 0, 1, 0, '0, 0);
      idle(2);

      // period 1 auto-reload: done on every tick
      step(0, 1, 0, 1, 8'd1, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0, 1);
      chk("p1_periods", 64'(periods_o), 64'd9);
      step(0, 0, 1, 0, '0, 0);
      idle(2);

      // period 0 one-shot: 256 ticks
      step(0, 1, 0, 0, 8'd0, 1);
      for (int i = 0; i < 300 && m_active; i++) step(0, 0, 0, 0, '0, 1);
      idle(2);
      chk("p0_periods", 64'(periods_o), 64'd1);
      chk("p0_busy", 64'(busy_o), 64'd0);

      // stop colliding with a terminal event
      step(0, 1, 0, 1, 8'd3, 1);
      for (int i = 0; i < 20 && m_active; i++) begin
         saved = m_periods;
         step(0, 0, bit'(!m_loading && m_rem == 1 && i > 5), 1, 8'd3, 1);
      end
      idle(2);
      chk("collide_periods", 64'(periods_o), 64'(saved));
      chk("collide_busy", 64'(busy_o), 64'd0);

      // start with stop in idle
      step(0, 1, 1, 1, 8'd5, 1);
      idle(1);
      chk("startstop_busy", 64'(busy_o), 64'd0);

      // reset in the middle of a run
      step(0, 1, 0, 0, 8'd10, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0, 1);
      step(1, 0, 0, 0, '0, 1);
      chk("midreset_busy", 64'(busy_o), 64'd0);
      chk("midreset_mr_n", 64'(cnt_mr_n_o), 64'd0);
      idle(2);

      // 256 periods wrap the period counter
      step(0, 1, 0, 1, 8'd1, 1);
      for (int i = 0; i < 257; i++) step(0, 0, 0, 0, '0, 1);
      chk("wrap_periods", 64'(periods_o), 64'd0);
      step(0, 0, 1, 0, '0, 0);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] per;
         per = ($urandom % 2 == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
         step(bit'($urandom % 300 == 0), bit'($urandom % 12 == 0), bit'($urandom % 50 == 0),
              bit'($urandom % 2), per, bit'($urandom % 3 != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
